// File: rtl/hf_sample_writer.sv
// ----------------------------------------------------------------------------
// hf_sample_writer
//
// Output stage for decoded Huffman samples. Big-values pairs (x,y) and count1
// quads (v,w,x,y) are serialised onto a single BRAM write port, one sample per
// cycle, into the bank selected by granule/channel. Each bank is zero-filled up
// to NUM_SAMPLES and a sticky per-bank done flag is raised for the requantiser.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   si_valid        new frame side info: clears done and overflow
//   start           begin a stream; gr, ch, big_values sampled here
//   pair_valid      pair_x / pair_y valid (BIG state only)
//   quad_valid      quad_v..quad_y valid (COUNT1 state only)
//   part_end        pulse: part2_3 bits exhausted, finish and zero-fill
//   ready           an item may be accepted this cycle
//   wr_en, wr_bank, wr_addr, wr_data   BRAM write port
//   done            per-bank completion, sticky
//   overflow        sticky: big_values clamp, dropped lane, or part_end in BIG
//   nz_index        1 + address of last nonzero sample of the last completed
//                   stream; only tracked when HF_NZ_INDEX_EN is defined,
//                   otherwise tied to 0
//
// Build option
//   HF_NZ_INDEX_EN  enables nz_index tracking
// ----------------------------------------------------------------------------
// state   | meaning
// --------+-------------------------------------------------------------------
// S_IDLE  | waiting for start, ready=0
// S_BIG   | accepting big-values pairs until big_values pairs taken
// S_CNT1  | accepting count1 quads until part_end or the bank is full
// S_ZFILL | writing zeros from addr to NUM_SAMPLES-1, then flag done
// ----------------------------------------------------------------------------
module hf_sample_writer #(
   parameter int NUM_GR      = 2,
   parameter int NUM_CH      = 2,
   parameter int SAMPLE_W    = 16,
   parameter int NUM_SAMPLES = 576,
   parameter int ADDR_W      = 10
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               si_valid,
   input  logic                               start,
   input  logic [$clog2(NUM_GR)-1:0]          gr,
   input  logic [$clog2(NUM_CH)-1:0]          ch,
   input  logic [8:0]                         big_values,
   input  logic                               pair_valid,
   input  logic [SAMPLE_W-1:0]                pair_x,
   input  logic [SAMPLE_W-1:0]                pair_y,
   input  logic                               quad_valid,
   input  logic [SAMPLE_W-1:0]                quad_v,
   input  logic [SAMPLE_W-1:0]                quad_w,
   input  logic [SAMPLE_W-1:0]                quad_x,
   input  logic [SAMPLE_W-1:0]                quad_y,
   input  logic                               part_end,
   output logic                               ready,
   output logic                               wr_en,
   output logic [$clog2(NUM_GR*NUM_CH)-1:0]   wr_bank,
   output logic [ADDR_W-1:0]                  wr_addr,
   output logic [SAMPLE_W-1:0]                wr_data,
   output logic [NUM_GR*NUM_CH-1:0]           done,
   output logic                               overflow,
   output logic [ADDR_W-1:0]                  nz_index
);

   localparam int NB = NUM_GR * NUM_CH;
   localparam int BW = $clog2(NB);
   // One extra address bit so the "bank full" value NUM_SAMPLES is always
   // representable, even when 2^ADDR_W == NUM_SAMPLES.
   localparam int AW = ADDR_W + 1;
   localparam int PW = (ADDR_W > 9) ? ADDR_W : 9;

   localparam logic [AW-1:0] A_END  = AW'(NUM_SAMPLES);
   localparam logic [AW-1:0] A_LAST = AW'(NUM_SAMPLES - 1);
   localparam logic [AW-1:0] A_ONE  = AW'(1);
   localparam logic [PW-1:0] P_HALF = PW'(NUM_SAMPLES / 2);
   localparam logic [PW-1:0] P_ONE  = PW'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BIG   = 2'd1,
      S_CNT1  = 2'd2,
      S_ZFILL = 2'd3
   } state_t;

   state_t                       state_q, state_d;
   logic [AW-1:0]                addr_q, addr_d;
   logic [PW-1:0]                pairs_q, pairs_d;
   logic [2:0]                   cnt_q, cnt_d;
   logic [3:0][SAMPLE_W-1:0]     lane_q, lane_d;
   logic [BW-1:0]                bank_q, bank_d;
   logic                         enter_q, enter_d;
   logic                         pend_q, pend_d;
   logic [NB-1:0]                done_q, done_d;
   logic                         ovf_q, ovf_d;

   logic                         emit;
   logic                         in_range;
   logic [AW-1:0]                addr_adv;
   logic                         streaming;
   logic                         ready_c;
   logic                         take_pair;
   logic                         take_quad;
   logic                         idle_after;
   logic                         end_req;
   logic [PW-1:0]                bv_ext;

   logic                         wr_en_c;
   logic [SAMPLE_W-1:0]          wr_data_c;
   logic                         ovf_set;
   logic                         done_set;

   // cnt_q counts lanes still to be emitted, including the one on the port now.
   assign emit      = (cnt_q != 3'd0);
   assign in_range  = (addr_q < A_END);
   // Address the next accepted item would start at.
   assign addr_adv  = (emit && in_range) ? (addr_q + A_ONE) : addr_q;
   assign streaming = (state_q == S_BIG) || (state_q == S_CNT1);
   // Accept only when the current item is on its final lane (or none is in
   // flight), no end is pending, and there is still room in the bank.
   assign ready_c   = streaming && !enter_q && !pend_q &&
                      (cnt_q <= 3'd1) && (addr_adv < A_END);
   assign take_pair = (state_q == S_BIG)  && ready_c && pair_valid;
   assign take_quad = (state_q == S_CNT1) && ready_c && quad_valid;
   assign idle_after = (cnt_q <= 3'd1) && !take_pair && !take_quad;
   assign end_req   = pend_q || part_end;
   assign bv_ext    = PW'(big_values);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      pairs_d   = pairs_q;
      cnt_d     = cnt_q;
      lane_d    = lane_q;
      bank_d    = bank_q;
      enter_d   = 1'b0;
      pend_d    = pend_q;
      wr_en_c   = 1'b0;
      wr_data_c = '0;
      ovf_set   = 1'b0;
      done_set  = 1'b0;

      // Lane emitter: drops lanes that fall past the end of the bank.
      if (emit) begin
         wr_en_c   = in_range;
         wr_data_c = lane_q[0];
         lane_d    = {{SAMPLE_W{1'b0}}, lane_q[3:1]};
         cnt_d     = cnt_q - 3'd1;
         addr_d    = addr_adv;
         if (!in_range) ovf_set = 1'b1;
      end

      if (take_pair) begin
         lane_d = {{(2*SAMPLE_W){1'b0}}, pair_y, pair_x};
         cnt_d  = 3'd2;
      end else if (take_quad) begin
         lane_d = {quad_y, quad_x, quad_w, quad_v};
         cnt_d  = 3'd4;
      end

      if (streaming && part_end) begin
         pend_d = 1'b1;
         if (state_q == S_BIG) ovf_set = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            pend_d = 1'b0;
            if (start) begin
               bank_d  = BW'(int'(gr) * NUM_CH + int'(ch));
               addr_d  = '0;
               cnt_d   = 3'd0;
               enter_d = 1'b1;
               if (bv_ext > P_HALF) begin
                  pairs_d = P_HALF;
                  ovf_set = 1'b1;
               end else begin
                  pairs_d = bv_ext;
               end
               state_d = (big_values != 9'd0) ? S_BIG : S_CNT1;
            end
         end
         S_BIG: begin
            if (take_pair) begin
               pairs_d = pairs_q - P_ONE;
               if (pairs_q == P_ONE) state_d = S_CNT1;
            end else if (end_req && idle_after) begin
               state_d = S_ZFILL;
            end
         end
         S_CNT1: begin
            if (idle_after && (end_req || (addr_adv >= A_END)))
               state_d = S_ZFILL;
         end
         S_ZFILL: begin
            pend_d    = 1'b0;
            wr_en_c   = in_range;
            wr_data_c = '0;
            if (in_range) addr_d = addr_q + A_ONE;
            if (addr_q >= A_LAST) begin
               done_set = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Set beats clear when si_valid coincides with a new event.
      done_d = si_valid ? '0 : done_q;
      if (done_set) done_d[bank_q] = 1'b1;
      ovf_d = si_valid ? 1'b0 : ovf_q;
      if (ovf_set) ovf_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         pairs_q <= '0;
         cnt_q   <= '0;
         lane_q  <= '0;
         bank_q  <= '0;
         enter_q <= 1'b0;
         pend_q  <= 1'b0;
         done_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         pairs_q <= pairs_d;
         cnt_q   <= cnt_d;
         lane_q  <= lane_d;
         bank_q  <= bank_d;
         enter_q <= enter_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   assign ready    = ready_c;
   assign wr_en    = wr_en_c;
   assign wr_bank  = bank_q;
   assign wr_addr  = addr_q[ADDR_W-1:0];
   assign wr_data  = wr_data_c;
   assign done     = done_q;
   assign overflow = ovf_q;

`ifdef HF_NZ_INDEX_EN
   logic [AW-1:0]     nz_run_q, nz_run_d;
   logic [ADDR_W-1:0] nz_q, nz_d;

   // ZFILL only writes zeros, so nz_run_q is final by the time done is set.
   always_comb begin
      nz_run_d = nz_run_q;
      nz_d     = nz_q;
      if ((state_q == S_IDLE) && start)
         nz_run_d = '0;
      else if (wr_en_c && (wr_data_c != '0))
         nz_run_d = addr_q + A_ONE;
      if (done_set) nz_d = nz_run_q[ADDR_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         nz_run_q <= '0;
         nz_q     <= '0;
      end else begin
         nz_run_q <= nz_run_d;
         nz_q     <= nz_d;
      end
   end

   assign nz_index = nz_q;
`else
   assign nz_index = '0;
`endif

endmodule

// File: doc/hf_sample_writer.md
Name: hf_sample_writer

Overview:
Parametrised successor to the Huffman plexer output stage of the MP3 decoder.
- Accepts decoded Huffman samples from the bitstream decoder: big-values pairs (x,y) and count1 quads (v,w,x,y).
- Serialises them onto one BRAM write port, one sample per cycle, into a bank selected by granule/channel.
- Zero-fills each bank to NUM_SAMPLES and flags per-bank completion for the requantiser.

Parameters:
NUM_GR, 2, granules per frame
NUM_CH, 2, channels per granule
SAMPLE_W, 16, signed sample width
NUM_SAMPLES, 576, samples per granule/channel bank
ADDR_W, 10, write address width (2^ADDR_W >= NUM_SAMPLES)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
si_valid  in  1  new frame side info; clears done and overflow
start  in  1  begin stream for latched gr/ch/big_values
gr  in  $clog2(NUM_GR)  granule select, sampled on start
ch  in  $clog2(NUM_CH)  channel select, sampled on start
big_values  in  9  number of (x,y) pairs, sampled on start
pair_valid  in  1  pair_x/pair_y valid
pair_x, pair_y  in  SAMPLE_W each  big-values pair
quad_valid  in  1  quad inputs valid
quad_v, quad_w, quad_x, quad_y  in  SAMPLE_W each  count1 quad
part_end  in  1  pulse: part2_3 bits exhausted
ready  out  1  pair/quad may be accepted this cycle
wr_en  out  1  BRAM write strobe
wr_bank  out  $clog2(NUM_GR*NUM_CH)  bank = gr*NUM_CH+ch
wr_addr  out  ADDR_W  sample index
wr_data  out  SAMPLE_W  sample
done  out  NUM_GR*NUM_CH  per-bank complete, sticky
overflow  out  1  sticky: clamp/truncation/protocol error
nz_index  out  ADDR_W  see Optional Feature

Behaviour:
- One clock (clk); synchronous active-high reset (rst).
- Reset clears all outputs and counters to 0 and puts the FSM in IDLE; ready=0.
- States:
  - IDLE: start → BIG if big_values>0, else COUNT1; addr←0. start outside IDLE is ignored.
  - BIG: accepts pair_valid&ready; quad_valid ignored. After the big_values-th pair is accepted → COUNT1.
  - COUNT1: accepts quad_valid&ready; pair_valid ignored.
  - part_end in BIG or COUNT1 → ZFILL once the in-flight item finishes emitting. part_end in BIG also sets overflow.
  - ZFILL: writes 0 each cycle from current addr to NUM_SAMPLES-1. done[bank] is set the cycle after the last write; then → IDLE.
  - If addr==NUM_SAMPLES on entry to ZFILL, there are no writes; done is set the next cycle.
- Emission:
  - Item accepted at cycle t writes lane0 at t+1, lane1 at t+2, and so on, in order x,y or v,w,x,y, at consecutive addresses.
  - ready=0 during the item's non-final lanes and =1 in the cycle of its final lane.
  - Throughput: one pair per 2 cycles, one quad per 4 cycles.
  - ready=0 in IDLE, ZFILL, and the cycle after entering BIG/COUNT1.
- big_values>NUM_SAMPLES/2 clamps to NUM_SAMPLES/2 and sets overflow.
- Lanes falling at addr>=NUM_SAMPLES are dropped (no wr_en) and set overflow. Reaching addr==NUM_SAMPLES in COUNT1 → ZFILL (zero writes).
- si_valid clears done and overflow in any state and does not abort an active stream. If si_valid and done-set coincide, the set wins.
- rst mid-stream aborts immediately; partially written banks remain not done.

Optional Feature:
HF_NZ_INDEX_EN
- Defined: tracks 1 + address of the last nonzero sample written in the stream (0 if none). The value is latched onto nz_index when done is set and held until the next done set or rst.
- Undefined: nz_index tied to 0; no tracking logic.

Test Plan:
- rst, start gr=0 ch=0 big_values=2, pairs (3,-1),(0,5) back-to-back, then quad (1,0,-1,0), part_end → writes addr0..7 = 3,-1,0,5,1,0,-1,0; zeros at 8..575; done=4'b0001; nz_index=7 with HF_NZ_INDEX_EN.
- start gr=1 ch=0 big_values=0, part_end immediately → 576 zero writes to bank 2; done[2]=1; nz_index=0.
- big_values=300 → clamped to 288 pairs; overflow=1; quad_valid ignored until the 288th pair; then COUNT1 at addr 576 → ZFILL with zero writes; done set.
- Quad accepted at addr 574 → v,w written at 574,575; x,y dropped; overflow=1; done set without part_end.
- pair_valid held high continuously → ready toggles 1,0,1,0; wr_en continuously high; consecutive addresses; quad stream gives ready high every 4th cycle.
- rst asserted mid-BIG → next cycle ready=0, wr_en=0, done unchanged (0); si_valid after completion clears done and overflow.
